// File: rtl/frame_tx_sequencer.sv
// frame_tx_sequencer
//   Controller for the frame assembler. Moves one burst of IFFT+CP bytes from
//   the upstream stream into the assembler. It then waits for the assembled
//   frame (preamble followed by data) to be ready and streams it to the DAC at
//   a divided sample rate. Finally it pulses tx_done to re-arm the assembler.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   enable_i              allow new frames to start (sampled in IDLE and at end of GAP)
//   s_data_i/s_valid_i    upstream byte stream; s_ready_o is high only in LOAD
//   asm_din_o/asm_wren_o  assembler write port (pass-through of the upstream handshake)
//   asm_tx_done_o         clears assembler buffers; high in DONE and throughout reset
//   asm_read_ptr_o        assembler read address during STREAM
//   asm_full_i            assembler output buffer full
//   asm_dout_i            assembler read data, one cycle after read_ptr
//   dac_data_o/dac_valid_o  DAC sample and one-cycle strobe per sample
//   busy_o                state != IDLE
//   frame_cnt_o           frames streamed to completion, wraps at 0xFFFF
//   err_timeout_o         sticky: asm_full never arrived; cleared only by reset
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for enable
// LOAD      | accepting FRAME_IN_LEN bytes into the assembler
// WAIT_FULL | waiting for asm_full, bounded by TIMEOUT_CYCLES
// STREAM    | reading the frame out, one DAC sample per SAMPLE_DIV cycles
// DONE      | one-cycle asm_tx_done pulse, frame counter update
// GAP       | GAP_CYCLES idle cycles before the next frame

module frame_tx_sequencer #(
    parameter int FRAME_IN_LEN   = 640,
    parameter int FRAME_OUT_LEN  = 1120,
    parameter int PTR_W          = 11,
    parameter int SAMPLE_DIV     = 4,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [7:0]       asm_din_o,
    output logic             asm_wren_o,
    output logic             asm_tx_done_o,
    output logic [PTR_W-1:0] asm_read_ptr_o,
    input  logic             asm_full_i,
    input  logic [7:0]       asm_dout_i,
    output logic [7:0]       dac_data_o,
    output logic             dac_valid_o,
    output logic             busy_o,
    output logic [15:0]      frame_cnt_o,
    output logic             err_timeout_o
);

    localparam int LOAD_W  = $clog2(FRAME_IN_LEN);
    localparam int TMR_MAX0 = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TMR_MAX  = (TMR_MAX0 > SAMPLE_DIV) ? TMR_MAX0 : SAMPLE_DIV;
    localparam int TMR_W    = $clog2(TMR_MAX);

    localparam logic [LOAD_W-1:0] LAST_IN  = LOAD_W'(FRAME_IN_LEN - 1);
    localparam logic [LOAD_W-1:0] LOAD_ONE = LOAD_W'(1);
    localparam logic [PTR_W-1:0]  LAST_OUT = PTR_W'(FRAME_OUT_LEN - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [TMR_W-1:0]  TMO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  DIV_LOAD = TMR_W'(SAMPLE_DIV - 1);
    localparam logic [TMR_W-1:0]  GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_FULL,
        ST_STREAM,
        ST_DONE,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
    // One shared down-counter: timeout in WAIT_FULL, sample hold in STREAM, GAP length.
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d;
    // Marks the current frame as the timeout path so DONE does not count it.
    logic              to_q, to_d;

    logic s_ready;
    logic wren;
    logic dac_valid;
    logic tx_done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            load_cnt_q  <= '0;
            tmr_q       <= '0;
            ptr_q       <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            tmr_q       <= tmr_d;
            ptr_q       <= ptr_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            to_q        <= to_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        tmr_d       = tmr_q;
        ptr_d       = ptr_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        to_d        = to_q;
        s_ready     = (state_q == ST_LOAD);
        // Gated by rst_i so a reset cycle never produces a write or a strobe.
        wren        = s_valid_i & s_ready & ~rst_i;
        dac_valid   = 1'b0;
        tx_done     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (wren) begin
                    if (load_cnt_q == LAST_IN) begin
                        state_d    = ST_WAIT_FULL;
                        load_cnt_d = '0;
                        tmr_d      = TMO_LOAD;
                    end else begin
                        load_cnt_d = load_cnt_q + LOAD_ONE;
                    end
                end
            end
            ST_WAIT_FULL: begin
                if (asm_full_i) begin
                    state_d = ST_STREAM;
                    tmr_d   = DIV_LOAD;
                    ptr_d   = '0;
                end else if (tmr_q == '0) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_STREAM: begin
                // Strobe on the last cycle of each hold so the registered
                // asm_dout already reflects the current pointer.
                if (tmr_q == '0) begin
                    dac_valid = ~rst_i;
                    if (ptr_q == LAST_OUT) begin
                        state_d = ST_DONE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + PTR_ONE;
                        tmr_d = DIV_LOAD;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_DONE: begin
                tx_done = 1'b1;
                if (!to_q) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
                to_d    = 1'b0;
                state_d = ST_GAP;
                tmr_d   = GAP_LOAD;
            end
            ST_GAP: begin
                if (tmr_q == '0) begin
                    state_d    = enable_i ? ST_LOAD : ST_IDLE;
                    load_cnt_d = '0;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign s_ready_o      = s_ready;
    assign asm_din_o      = s_data_i;
    assign asm_wren_o     = wren;
    assign asm_tx_done_o  = tx_done | rst_i;
    assign asm_read_ptr_o = ptr_q;
    assign dac_data_o     = asm_dout_i;
    assign dac_valid_o    = dac_valid;
    assign busy_o         = (state_q != ST_IDLE);
    assign frame_cnt_o    = frame_cnt_q;
    assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_frame_tx_sequencer.sv
module tb_frame_tx_sequencer;

    localparam int IN_LEN  = 640;
    localparam int OUT_LEN = 1120;
    localparam int PRE_LEN = 480;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  asm_din;
    logic        asm_wren;
    logic        asm_tx_done;
    logic [10:0] asm_read_ptr;
    logic        asm_full = 1'b0;
    logic [7:0]  asm_dout = 8'd0;
    logic [7:0]  dac_data;
    logic        dac_valid;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        err_timeout;

    always #5 clk = ~clk;

    frame_tx_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .s_data_i       (s_data),
        .s_valid_i      (s_valid),
        .s_ready_o      (s_ready),
        .asm_din_o      (asm_din),
        .asm_wren_o     (asm_wren),
        .asm_tx_done_o  (asm_tx_done),
        .asm_read_ptr_o (asm_read_ptr),
        .asm_full_i     (asm_full),
        .asm_dout_i     (asm_dout),
        .dac_data_o     (dac_data),
        .dac_valid_o    (dac_valid),
        .busy_o         (busy),
        .frame_cnt_o    (frame_cnt),
        .err_timeout_o  (err_timeout)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pre_byte(input int i);
        case (i)
            0: return 8'hE4;
            1: return 8'hFE;
            2: return 8'h05;
            3: return 8'hFD;
            default: return 8'((i * 7 + 3) & 255);
        endcase
    endfunction

    // Assembler model: data bytes land after the fixed preamble; registered read.
    logic [7:0] dmem [IN_LEN];
    int  wptr    = 0;
    bit  full_en = 1'b1;

    always @(posedge clk) begin
        if (asm_tx_done) begin
            wptr     <= 0;
            asm_full <= 1'b0;
        end else begin
            if (asm_wren && wptr < IN_LEN) begin
                dmem[wptr] <= asm_din;
                wptr       <= wptr + 1;
            end
            if (wptr == IN_LEN && full_en) asm_full <= 1'b1;
        end
        if (int'(asm_read_ptr) < PRE_LEN)
            asm_dout <= pre_byte(int'(asm_read_ptr));
        else if (int'(asm_read_ptr) < OUT_LEN)
            asm_dout <= dmem[int'(asm_read_ptr) - PRE_LEN];
    end

    // Monitor: accumulates event counts and per-sample errors for the tasks to check.
    int wren_n = 0, bad_wren = 0, bad_din = 0;
    int strobe_n = 0, bad_data = 0, bad_ptr = 0, sidx = 0;
    int done_n = 0, done_cyc = 0, last_wren_cyc = 0;
    int first_strobe_cyc = 0, last_strobe_cyc = 0;
    int gap_seen = 0, gap_bad = 0;
    int cur_base = 0;
    bit armed = 1'b0;
    logic prev_ready = 1'b0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (rst) begin
            sidx  = 0;
            armed = 1'b0;
        end else begin
            if (asm_wren) begin
                wren_n++;
                last_wren_cyc = cyc;
                if (!s_valid) bad_wren++;
                if (asm_din !== s_data) bad_din++;
            end
            if (dac_valid) begin
                exp_b = (sidx < PRE_LEN) ? pre_byte(sidx) : 8'(sidx - PRE_LEN + cur_base);
                if (dac_data !== exp_b) bad_data++;
                if (asm_read_ptr !== 11'(sidx)) bad_ptr++;
                if (sidx == 0) first_strobe_cyc = cyc;
                last_strobe_cyc = cyc;
                strobe_n++;
                sidx++;
            end
            if (asm_tx_done) begin
                done_n++;
                done_cyc = cyc;
                sidx     = 0;
                armed    = 1'b1;
            end
            if (s_ready && !prev_ready && armed) begin
                gap_seen++;
                if (cyc - done_cyc != 65) gap_bad++;
                armed = 1'b0;
            end
            if (!busy) armed = 1'b0;
        end
        prev_ready = s_ready;
    end

    task automatic send_frame(input int base, input bit bubbles);
        int idx = 0;
        int n = 0;
        bit hs;
        cur_base = base;
        @(posedge clk); #1;
        s_data  = 8'(base);
        s_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
        while (idx < IN_LEN && n < 20000) begin
            @(negedge clk);
            n++;
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            s_data  = 8'(idx + base);
            s_valid = (idx < IN_LEN) && (bubbles ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
        s_valid = 1'b0;
        compared++;
        if (idx != IN_LEN) begin
            mismatched++;
            $display("FAIL load_complete: accepted %0d bytes, required %0d", idx, IN_LEN);
        end
    endtask

    task automatic wait_done(input int prev);
        for (int n = 0; n < 15000 && done_n == prev; n++) @(negedge clk);
        compared++;
        if (done_n == prev) begin
            mismatched++;
            $display("FAIL wait_done: no asm_tx_done within bound, count %0d", done_n);
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300 && busy; n++) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL wait_idle: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({s_ready, asm_wren, dac_valid, busy, err_timeout} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {s_ready, asm_wren, dac_valid, busy, err_timeout});
        end
        compared++;
        if (asm_read_ptr !== 11'd0) begin
            mismatched++;
            $display("FAIL reset_ptr: got %0d, required 0", asm_read_ptr);
        end
        compared++;
        if (frame_cnt !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt);
        end
        compared++;
        if (asm_tx_done !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_tx_done: got %b, required 1", asm_tx_done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (asm_tx_done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset: tx_done=%b busy=%b, required 0 0", asm_tx_done, busy);
        end
    endtask

    task automatic run_one_frame(input int base, input bit bubbles, input string name,
                                 input int exp_cnt);
        int w0 = wren_n, s0 = strobe_n, d0 = done_n;
        int bd0 = bad_data, bw0 = bad_wren, bi0 = bad_din, bp0 = bad_ptr;
        enable = 1'b1;
        send_frame(base, bubbles);
        enable = 1'b0;
        wait_done(d0);
        wait_idle();
        compared++;
        if (wren_n - w0 != IN_LEN) begin
            mismatched++;
            $display("FAIL %s_wren_count: got %0d, required %0d", name, wren_n - w0, IN_LEN);
        end
        compared++;
        if (strobe_n - s0 != OUT_LEN) begin
            mismatched++;
            $display("FAIL %s_strobe_count: got %0d, required %0d", name, strobe_n - s0, OUT_LEN);
        end
        compared++;
        if (bad_data != bd0 || bad_ptr != bp0) begin
            mismatched++;
            $display("FAIL %s_samples: %0d data and %0d ptr errors, required 0", name,
                     bad_data - bd0, bad_ptr - bp0);
        end
        compared++;
        if (bad_wren != bw0 || bad_din != bi0) begin
            mismatched++;
            $display("FAIL %s_writes: %0d without valid, %0d din errors, required 0", name,
                     bad_wren - bw0, bad_din - bi0);
        end
        compared++;
        if (done_n - d0 != 1) begin
            mismatched++;
            $display("FAIL %s_done_count: got %0d, required 1", name, done_n - d0);
        end
        compared++;
        if (last_strobe_cyc - first_strobe_cyc != (OUT_LEN - 1) * 4) begin
            mismatched++;
            $display("FAIL %s_stream_span: got %0d, required %0d", name,
                     last_strobe_cyc - first_strobe_cyc, (OUT_LEN - 1) * 4);
        end
        compared++;
        if (frame_cnt !== 16'(exp_cnt)) begin
            mismatched++;
            $display("FAIL %s_frame_cnt: got %0d, required %0d", name, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_nominal();
        run_one_frame(0, 1'b0, "nominal", 1);
    endtask

    task automatic test_bubbles();
        run_one_frame(0, 1'b1, "bubbles", 2);
    endtask

    task automatic test_timeout();
        int s0 = strobe_n, d0 = done_n;
        full_en = 1'b0;
        enable  = 1'b1;
        send_frame(100, 1'b0);
        enable  = 1'b0;
        wait_done(d0);
        wait_idle();
        full_en = 1'b1;
        compared++;
        if (err_timeout !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_err: got %b, required 1", err_timeout);
        end
        compared++;
        if (strobe_n != s0) begin
            mismatched++;
            $display("FAIL timeout_strobes: got %0d, required 0", strobe_n - s0);
        end
        compared++;
        if (done_n - d0 != 1) begin
            mismatched++;
            $display("FAIL timeout_done_count: got %0d, required 1", done_n - d0);
        end
        compared++;
        if (done_cyc - last_wren_cyc != 4097) begin
            mismatched++;
            $display("FAIL timeout_length: got %0d, required 4097", done_cyc - last_wren_cyc);
        end
        compared++;
        if (frame_cnt !== 16'd2) begin
            mismatched++;
            $display("FAIL timeout_frame_cnt: got %0d, required 2", frame_cnt);
        end
    endtask

    task automatic test_enable_drop();
        int s0 = strobe_n, d0 = done_n, bd0 = bad_data;
        enable = 1'b1;
        fork
            send_frame(50, 1'b0);
            begin
                for (int n = 0; n < 100 && !s_ready; n++) @(negedge clk);
                repeat (100) @(posedge clk);
                #1 enable = 1'b0;
            end
        join
        wait_done(d0);
        wait_idle();
        compared++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL enable_drop_idle: s_ready=%b busy=%b, required 0 0", s_ready, busy);
        end
        compared++;
        if (strobe_n - s0 != OUT_LEN || bad_data != bd0) begin
            mismatched++;
            $display("FAIL enable_drop_stream: %0d strobes, %0d data errors, required %0d and 0",
                     strobe_n - s0, bad_data - bd0, OUT_LEN);
        end
        compared++;
        if (frame_cnt !== 16'd3) begin
            mismatched++;
            $display("FAIL enable_drop_frame_cnt: got %0d, required 3", frame_cnt);
        end
    endtask

    task automatic test_reset_mid_stream();
        int s0;
        enable = 1'b1;
        send_frame(200, 1'b0);
        enable = 1'b0;
        for (int n = 0; n < 3000 && asm_read_ptr != 11'd300; n++) @(negedge clk);
        compared++;
        if (asm_read_ptr !== 11'd300) begin
            mismatched++;
            $display("FAIL midrst_reach_ptr: got %0d, required 300", asm_read_ptr);
        end
        #1 rst = 1'b1;
        s0 = strobe_n;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || asm_read_ptr !== 11'd0 || dac_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_abort: busy=%b ptr=%0d dac_valid=%b, required 0 0 0",
                     busy, asm_read_ptr, dac_valid);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (asm_tx_done !== 1'b1 || strobe_n != s0) begin
            mismatched++;
            $display("FAIL midrst_hold: tx_done=%b strobes=%0d, required 1 0",
                     asm_tx_done, strobe_n - s0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (asm_tx_done !== 1'b0 || frame_cnt !== 16'd0 || err_timeout !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_release: tx_done=%b frame_cnt=%0d err=%b, required 0 0 0",
                     asm_tx_done, frame_cnt, err_timeout);
        end
    endtask

    task automatic test_back_to_back();
        int g0 = gap_seen, gb0 = gap_bad, w0 = wren_n, bd0 = bad_data;
        int s0, d0;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s0 = strobe_n;
            d0 = done_n;
            send_frame(37 * k + 9, 1'b0);
            wait_done(d0);
            if (k == 2) enable = 1'b0;
            compared++;
            if (strobe_n - s0 != OUT_LEN) begin
                mismatched++;
                $display("FAIL b2b_strobes_frame%0d: got %0d, required %0d", k, strobe_n - s0,
                         OUT_LEN);
            end
        end
        wait_idle();
        compared++;
        if (frame_cnt !== 16'd3) begin
            mismatched++;
            $display("FAIL b2b_frame_cnt: got %0d, required 3", frame_cnt);
        end
        compared++;
        if (gap_seen - g0 != 2 || gap_bad != gb0) begin
            mismatched++;
            $display("FAIL b2b_gap: %0d gaps seen, %0d wrong, required 2 and 0",
                     gap_seen - g0, gap_bad - gb0);
        end
        compared++;
        if (wren_n - w0 != 3 * IN_LEN || bad_data != bd0) begin
            mismatched++;
            $display("FAIL b2b_data: %0d writes, %0d data errors, required %0d and 0",
                     wren_n - w0, bad_data - bd0, 3 * IN_LEN);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bubbles();
        test_timeout();
        test_enable_drop();
        test_reset_mid_stream();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
